// File: rtl/vga_frame_fetcher.sv
// Read-side frame scheduler: walks one bank of the framebuffer per frame in fixed
// SDRAM bursts and streams the returned words into the VGA scan-out FIFO.
module vga_frame_fetcher #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BURST_LEN  = 128,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [1:0]  display_bank,
    output logic        rd_burst_req,
    output logic [9:0]  rd_burst_len,
    output logic [23:0] rd_burst_addr,
    input  logic [15:0] rd_burst_data,
    input  logic        rd_burst_data_valid,
    input  logic        rd_burst_finish,
    output logic        fifo_clr,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    input  logic [9:0]  fifo_wr_count,
    output logic        frame_done,
    output logic        beat_err
);

    localparam int          TOTAL_BURSTS = H_RES * V_RES / BURST_LEN;
    localparam logic [11:0] TOTAL_B      = 12'(TOTAL_BURSTS);
    localparam logic [21:0] ADDR_STEP    = 22'(BURST_LEN);
    localparam logic [10:0] BURST_W      = 11'(BURST_LEN);
    localparam logic [10:0] DEPTH_W      = 11'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FLUSH      = 3'd1;
    localparam logic [2:0] S_WAIT_SPACE = 3'd2;
    localparam logic [2:0] S_BURST      = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [1:0]  bank_q;
    logic [1:0]  pend_bank;
    logic        pend_q;
    logic [21:0] addr_q;
    logic [11:0] burst_cnt;
    logic [10:0] beat_cnt;
    logic        req_q;
    logic        clr_q;
    logic        done_q;
    logic        err_q;
    logic        vld_p1;
    logic [15:0] wr_data_p1;

    logic        restart;
    logic        advance;
    logic [10:0] free_space;
    logic [10:0] beats_now;
    logic        last_burst;

    always_comb begin
        free_space = DEPTH_W - {1'b0, fifo_wr_count};
        beats_now  = beat_cnt + 11'(rd_burst_data_valid);
        last_burst = (burst_cnt == TOTAL_B - 12'd1);
        restart    = 1'b0;
        advance    = 1'b0;
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (frame_start) begin
                    restart    = 1'b1;
                    next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (frame_start) begin
                    restart    = 1'b1;
                    next_state = S_FLUSH;
                end else begin
                    next_state = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (frame_start) begin
                    restart    = 1'b1;
                    next_state = S_FLUSH;
                end else if (free_space >= BURST_W) begin
                    next_state = S_BURST;
                end
            end
            S_BURST: begin
                // A burst in flight is never aborted; a new frame takes over at its end.
                if (rd_burst_finish) begin
                    if (frame_start || pend_q) begin
                        restart    = 1'b1;
                        next_state = S_FLUSH;
                    end else begin
                        advance    = 1'b1;
                        next_state = last_burst ? S_DONE : S_WAIT_SPACE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bank_q    <= 2'd0;
            pend_bank <= 2'd0;
            pend_q    <= 1'b0;
            addr_q    <= 22'd0;
            burst_cnt <= 12'd0;
            beat_cnt  <= 11'd0;
            req_q     <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            req_q <= (next_state == S_BURST);
            clr_q <= (next_state == S_FLUSH);
            done_q <= (next_state == S_DONE);

            if (restart) begin
                // The most recent frame_start decides the bank.
                bank_q    <= frame_start ? display_bank : pend_bank;
                pend_q    <= 1'b0;
                addr_q    <= 22'd0;
                burst_cnt <= 12'd0;
            end else begin
                if (state == S_BURST && frame_start) begin
                    pend_q    <= 1'b1;
                    pend_bank <= display_bank;
                end
                if (advance) begin
                    addr_q    <= addr_q + ADDR_STEP;
                    burst_cnt <= burst_cnt + 12'd1;
                end
            end

            if (state == S_BURST && !rd_burst_finish) begin
                beat_cnt <= beats_now;
            end else begin
                beat_cnt <= 11'd0;
            end

            if (state == S_BURST && rd_burst_finish && beats_now != BURST_W) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stage p1: registered copy of the SDRAM return bus into the FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_data_p1 <= 16'd0;
        end else begin
            vld_p1     <= rd_burst_data_valid;
            wr_data_p1 <= rd_burst_data;
        end
    end

    assign rd_burst_req  = req_q;
    assign rd_burst_len  = 10'(BURST_LEN);
    assign rd_burst_addr = {bank_q, addr_q};
    assign fifo_clr      = clr_q;
    assign fifo_wr_en    = vld_p1;
    assign fifo_wr_data  = wr_data_p1;
    assign frame_done    = done_q;
    assign beat_err      = err_q;

endmodule
